// File: rtl/mul_unit_if.sv
// Register-file side bundle for the multi-cycle multiplier: operand request in,
// write-back and flag-update request out.
interface mul_unit_if #(
    parameter int unsigned DBUSLEN = 32,
    parameter int unsigned ADDRLEN = 4
);
    logic               MUL_Start;
    logic               MUL_Accumulate;
    logic               MUL_Set_Flags;
    logic [ADDRLEN-1:0] MUL_Rd;
    logic [DBUSLEN-1:0] MUL_Op_M;
    logic [DBUSLEN-1:0] MUL_Op_S;
    logic [DBUSLEN-1:0] MUL_Op_N;
    logic               MUL_Busy;
    logic               MUL_Done;
    logic [DBUSLEN-1:0] MUL_Result;
    logic [ADDRLEN-1:0] MUL_Addr_Write;
    logic               MUL_Load_Write;
    logic               MUL_Flag_N;
    logic               MUL_Flag_Z;
    logic               MUL_Load_Flags;

    modport master (
        output MUL_Start, MUL_Accumulate, MUL_Set_Flags, MUL_Rd,
               MUL_Op_M, MUL_Op_S, MUL_Op_N,
        input  MUL_Busy, MUL_Done, MUL_Result, MUL_Addr_Write, MUL_Load_Write,
               MUL_Flag_N, MUL_Flag_Z, MUL_Load_Flags
    );

    modport slave (
        input  MUL_Start, MUL_Accumulate, MUL_Set_Flags, MUL_Rd,
               MUL_Op_M, MUL_Op_S, MUL_Op_N,
        output MUL_Busy, MUL_Done, MUL_Result, MUL_Addr_Write, MUL_Load_Write,
               MUL_Flag_N, MUL_Flag_Z, MUL_Load_Flags
    );
endinterface

// File: rtl/mul_unit.sv
// Multi-cycle MUL/MLA unit: shift-add over BITS_PER_CYCLE multiplier bits per cycle,
// stopping early once the remaining multiplier bits are all zero.
module mul_unit #(
    parameter int unsigned DBUSLEN        = 32,
    parameter int unsigned ADDRLEN        = 4,
    parameter int unsigned BITS_PER_CYCLE = 8
) (
    input logic        sysclk,
    input logic        reset,
    mul_unit_if.slave  mul_io
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StWb   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DBUSLEN-1:0] acc_q, acc_d;
    logic [DBUSLEN-1:0] mcand_q, mcand_d;
    logic [DBUSLEN-1:0] mplier_q, mplier_d;
    logic [ADDRLEN-1:0] rd_q, rd_d;
    logic               set_flags_q, set_flags_d;
    logic [DBUSLEN-1:0] result_q, result_d;
    logic [ADDRLEN-1:0] addr_q, addr_d;
    logic               done_q, done_d;
    logic               load_write_q, load_write_d;
    logic               load_flags_q, load_flags_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_z_q, flag_z_d;

    logic [DBUSLEN-1:0] partial;
    logic [DBUSLEN-1:0] acc_sum;
    logic [DBUSLEN-1:0] mplier_nxt;
    logic [DBUSLEN-1:0] mcand_nxt;

    // Low-slice partial product; only the low DBUSLEN bits ever matter.
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
        acc_sum    = acc_q + partial;
        mplier_nxt = mplier_q >> BITS_PER_CYCLE;
        mcand_nxt  = mcand_q << BITS_PER_CYCLE;
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        rd_d         = rd_q;
        set_flags_d  = set_flags_q;
        result_d     = result_q;
        addr_d       = addr_q;
        flag_n_d     = flag_n_q;
        flag_z_d     = flag_z_q;
        done_d       = 1'b0;
        load_write_d = 1'b0;
        load_flags_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (mul_io.MUL_Start) begin
                    acc_d       = mul_io.MUL_Accumulate ? mul_io.MUL_Op_N : '0;
                    mcand_d     = mul_io.MUL_Op_M;
                    mplier_d    = mul_io.MUL_Op_S;
                    rd_d        = mul_io.MUL_Rd;
                    set_flags_d = mul_io.MUL_Set_Flags;
                    state_d     = StCalc;
                end
            end
            StCalc: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_nxt;
                mplier_d = mplier_nxt;
                // Write-back outputs are registered here so they are stable across WB.
                if (mplier_nxt == '0) begin
                    state_d      = StWb;
                    done_d       = 1'b1;
                    result_d     = acc_sum;
                    addr_d       = rd_q;
                    load_write_d = (rd_q != '1);
                    flag_n_d     = acc_sum[DBUSLEN-1];
                    flag_z_d     = (acc_sum == '0);
                    load_flags_d = set_flags_q;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            rd_q         <= '0;
            set_flags_q  <= 1'b0;
            result_q     <= '0;
            addr_q       <= '0;
            done_q       <= 1'b0;
            load_write_q <= 1'b0;
            load_flags_q <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_z_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            rd_q         <= rd_d;
            set_flags_q  <= set_flags_d;
            result_q     <= result_d;
            addr_q       <= addr_d;
            done_q       <= done_d;
            load_write_q <= load_write_d;
            load_flags_q <= load_flags_d;
            flag_n_q     <= flag_n_d;
            flag_z_q     <= flag_z_d;
        end
    end

    assign mul_io.MUL_Busy       = (state_q != StIdle);
    assign mul_io.MUL_Done       = done_q;
    assign mul_io.MUL_Result     = result_q;
    assign mul_io.MUL_Addr_Write = addr_q;
    assign mul_io.MUL_Load_Write = load_write_q;
    assign mul_io.MUL_Flag_N     = flag_n_q;
    assign mul_io.MUL_Flag_Z     = flag_z_q;
    assign mul_io.MUL_Load_Flags = load_flags_q;
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Multi-cycle 32x32->32 multiplier for MUL/MLA.
- Consumes register-file read buses: Rm on Bus_A, Rs on Bus_B, Rn on Bus_C.
- Produces a register-file write-back request (Bus_Write/Addr_Write/Load_Write) and N/Z flag update.
- Shift-add over 8 multiplier bits per cycle, with early termination when the remaining Rs bits are zero.

Parameters:
- DBUSLEN, 32, operand/result width.
- ADDRLEN, 4, register address width.
- BITS_PER_CYCLE, 8, Rs bits consumed per CALC cycle; must divide DBUSLEN.

Ports:
- sysclk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- MUL_Start  input  1  request; sampled only in IDLE.
- MUL_Accumulate  input  1  1=MLA (add Rn), 0=MUL.
- MUL_Set_Flags  input  1  S bit; update N/Z at write-back.
- MUL_Rd  input  ADDRLEN  destination register.
- MUL_Op_M  input  DBUSLEN  Rm (multiplicand), from RF_Bus_A.
- MUL_Op_S  input  DBUSLEN  Rs (multiplier), from RF_Bus_B.
- MUL_Op_N  input  DBUSLEN  Rn (accumulate), from RF_Bus_C.
- MUL_Busy  output  1  high in CALC and WB.
- MUL_Done  output  1  one-cycle pulse in WB.
- MUL_Result  output  DBUSLEN  to RF_Bus_Write.
- MUL_Addr_Write  output  ADDRLEN  to RF_Addr_Write.
- MUL_Load_Write  output  1  to RF_Load_Write.
- MUL_Flag_N  output  1  result bit 31.
- MUL_Flag_Z  output  1  result == 0.
- MUL_Load_Flags  output  1  to RF_Load_Flags (N/Z merge done by the caller).

Behaviour:
- One clock (sysclk); reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; internal acc/mcand/mplier/rd 0.
- States are IDLE, CALC, WB.

IDLE:
- On MUL_Start=1 at an edge, latch:
  - acc = MUL_Accumulate ? MUL_Op_N : 0
  - mcand = MUL_Op_M
  - mplier = MUL_Op_S
  - rd, set_flags from the inputs.
- Next state is CALC.
- MUL_Start=0: stay in IDLE.

CALC (one edge per iteration):
- acc <= (acc + mcand * mplier[7:0]) mod 2^32.
- mcand <= mcand << 8 (zero fill).
- mplier <= mplier >> 8 (zero fill).
- If (mplier >> 8) == 0, go to WB; else stay in CALC.
- Iteration count n = max(1, index of highest nonzero byte of Rs + 1), so n is 1..4.
- Rs=0 gives n=1.

WB (exactly one cycle):
- MUL_Done=1.
- MUL_Result=acc, MUL_Addr_Write=rd.
- MUL_Load_Write=1 unless rd==4'hF, in which case it is 0 (PC write suppressed; Done still pulses).
- MUL_Flag_N=acc[31], MUL_Flag_Z=(acc==0), MUL_Load_Flags=set_flags.
- Next state is IDLE.
- Outputs are registered, so they are valid for the whole WB cycle.

Outside WB:
- MUL_Load_Write, MUL_Load_Flags and MUL_Done are 0.
- MUL_Result, MUL_Addr_Write and the flags are held at their last values.

Timing and boundary rules:
- Latency: Start sampled at edge k; WB is the cycle after edge k+n; Done is visible n+1 cycles after the start edge.
- Arithmetic: only the low 32 bits of the product are kept; this is identical for signed and unsigned operands.
- Operands are latched at start, so Rd==Rm/Rs/Rn aliasing has no effect.
- MUL_Start while Busy (CALC or WB) is ignored; there is no queueing and back-to-back starts are not taken in WB.
- Earliest new start is the cycle after WB.
- Reset in CALC or WB: next cycle is IDLE, all outputs 0, no write-back and no flag load issued.
- Reset has priority over Start.
- X on the operand inputs while in IDLE with Start=0 must not propagate to the outputs.

Test Plan:
1. MUL M=3, S=5, Rd=2, S-bit=0 -> 1 CALC; Done 2 cycles after start; Result=0x0000000F; Addr_Write=2; Load_Write=1; Load_Flags=0.
2. MLA M=0x00010000, S=0x00010000, N=7, Rd=4 -> 3 CALC cycles; Result=0x00000007 (2^32 truncated); Done at start+4.
3. MUL M=0xFFFFFFFF, S=0xFFFFFFFF, S-bit=1 -> 4 CALC; Result=0x00000001; N=0; Z=0; Load_Flags=1; Done at start+5.
4. MUL M=0x1234, S=0, S-bit=1 -> 1 CALC; Result=0; Z=1; N=0; Load_Flags=1. Repeat with M=2, S=0x40000000 -> 4 CALC; Result=0x80000000; N=1.
5. Rd=15, M=2, S=2 -> Done pulses; Result=4; Load_Write stays 0 throughout.
6. Start pulses during CALC and during WB -> ignored; Busy pattern unchanged. Reset asserted in 2nd CALC cycle of test 3 -> Busy=0 next cycle, no Load_Write/Done; a fresh start then completes normally.
